// File: rtl/morse_pkg.sv
// Shared Morse definitions: symbol codes, unit multipliers and the transmit FSM encoding.
// The decoder uses the same symbol constants.
package morse_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;

  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int SYM_GAP_UNITS    = 1;
  localparam int LETTER_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MARK  = 3'd1,
    SPACE = 3'd2,
    LGAP  = 3'd3,
    WGAP  = 3'd4
  } morse_state_e;

  // Five left-aligned slots; bits [9:8] hold the first symbol sent.
  typedef logic [9:0] morse_code_t;

  function automatic logic [1:0] slotOf(input morse_code_t code, input logic [2:0] idx);
    logic [1:0] sym;
    sym = SYM_NONE;
    case (idx)
      3'd0: sym = code[9:8];
      3'd1: sym = code[7:6];
      3'd2: sym = code[5:4];
      3'd3: sym = code[3:2];
      3'd4: sym = code[1:0];
      default: sym = SYM_NONE;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/morse_encoder_tx_if.sv
// Character handshake plus keying and symbol-slot outputs of the Morse transmitter.
interface morse_encoder_tx_if;
  logic [7:0] ascii_char;
  logic       start;
  logic       ready;
  logic       key_out;
  logic [1:0] morse_one;
  logic [1:0] morse_two;
  logic [1:0] morse_three;
  logic [1:0] morse_four;
  logic [1:0] morse_five;
  logic       letter_done;
  logic       done;
  logic       invalid;

  modport master (
    output ascii_char, start,
    input  ready, key_out, morse_one, morse_two, morse_three, morse_four, morse_five,
    input  letter_done, done, invalid
  );

  modport slave (
    input  ascii_char, start,
    output ready, key_out, morse_one, morse_two, morse_three, morse_four, morse_five,
    output letter_done, done, invalid
  );
endinterface

// File: rtl/morse_lookup.sv
// Combinational ASCII to Morse slot table; lowercase folds to uppercase.
// The decoder's table is the exact inverse of this one.
module morse_lookup
  import morse_pkg::*;
(
  input  logic [7:0]  ascii_i,
  output morse_code_t code_o,
  output logic        supported_o,
  output logic        is_space_o
);

  logic [7:0] upperChar;

  always_comb begin
    upperChar   = (ascii_i >= 8'h61 && ascii_i <= 8'h7A) ? (ascii_i - 8'h20) : ascii_i;
    code_o      = '0;
    supported_o = 1'b1;
    is_space_o  = 1'b0;
    case (upperChar)
      8'h41: code_o = 10'b01_10_00_00_00; // A .-
      8'h42: code_o = 10'b10_01_01_01_00; // B -...
      8'h43: code_o = 10'b10_01_10_01_00; // C -.-.
      8'h44: code_o = 10'b10_01_01_00_00; // D -..
      8'h45: code_o = 10'b01_00_00_00_00; // E .
      8'h46: code_o = 10'b01_01_10_01_00; // F ..-.
      8'h47: code_o = 10'b10_10_01_00_00; // G --.
      8'h48: code_o = 10'b01_01_01_01_00; // H ....
      8'h49: code_o = 10'b01_01_00_00_00; // I ..
      8'h4A: code_o = 10'b01_10_10_10_00; // J .---
      8'h4B: code_o = 10'b10_01_10_00_00; // K -.-
      8'h4C: code_o = 10'b01_10_01_01_00; // L .-..
      8'h4D: code_o = 10'b10_10_00_00_00; // M --
      8'h4E: code_o = 10'b10_01_00_00_00; // N -.
      8'h4F: code_o = 10'b10_10_10_00_00; // O ---
      8'h50: code_o = 10'b01_10_10_01_00; // P .--.
      8'h51: code_o = 10'b10_10_01_10_00; // Q --.-
      8'h52: code_o = 10'b01_10_01_00_00; // R .-.
      8'h53: code_o = 10'b01_01_01_00_00; // S ...
      8'h54: code_o = 10'b10_00_00_00_00; // T -
      8'h55: code_o = 10'b01_01_10_00_00; // U ..-
      8'h56: code_o = 10'b01_01_01_10_00; // V ...-
      8'h57: code_o = 10'b01_10_10_00_00; // W .--
      8'h58: code_o = 10'b10_01_01_10_00; // X -..-
      8'h59: code_o = 10'b10_01_10_10_00; // Y -.--
      8'h5A: code_o = 10'b10_10_01_01_00; // Z --..
      8'h30: code_o = 10'b10_10_10_10_10; // 0
      8'h31: code_o = 10'b01_10_10_10_10; // 1
      8'h32: code_o = 10'b01_01_10_10_10; // 2
      8'h33: code_o = 10'b01_01_01_10_10; // 3
      8'h34: code_o = 10'b01_01_01_01_10; // 4
      8'h35: code_o = 10'b01_01_01_01_01; // 5
      8'h36: code_o = 10'b10_01_01_01_01; // 6
      8'h37: code_o = 10'b10_10_01_01_01; // 7
      8'h38: code_o = 10'b10_10_10_01_01; // 8
      8'h39: code_o = 10'b10_10_10_10_01; // 9
      8'h20: is_space_o = 1'b1;
      default: supported_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/morse_encoder_tx.sv
// Morse transmitter: one ASCII character per handshake, timed on/off keying and
// decoder-compatible symbol slots with a completion pulse.
module morse_encoder_tx
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 5000000,
  parameter int CNT_W       = $clog2(7 * UNIT_CYCLES + 1)
) (
  input logic                clk,
  input logic                reset,
  morse_encoder_tx_if.slave  bus
);

  localparam logic [CNT_W-1:0] DOT_LOAD   = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LOAD  = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SGAP_LOAD  = CNT_W'(SYM_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LGAP_LOAD  = CNT_W'(LETTER_GAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WGAP_LOAD  = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES - 1);

  morse_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  morse_code_t      slots_q, slots_d;
  logic             key_q, key_d;
  logic             done_q, done_d;
  logic             invalid_q, invalid_d;

  morse_code_t lookupCode;
  logic        lookupSupported;
  logic        lookupSpace;
  logic [1:0]  nextSym;

  morse_lookup u_lookup (
    .ascii_i     (bus.ascii_char),
    .code_o      (lookupCode),
    .supported_o (lookupSupported),
    .is_space_o  (lookupSpace)
  );

  function automatic logic [CNT_W-1:0] markLoad(input logic [1:0] sym);
    return (sym == SYM_DASH) ? DASH_LOAD : DOT_LOAD;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      slots_q   <= '0;
      key_q     <= 1'b0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      slots_q   <= slots_d;
      key_q     <= key_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
    end
  end

  // Each timed state loads duration-1 on entry and leaves when the counter hits zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    slots_d   = slots_q;
    key_d     = key_q;
    done_d    = 1'b0;
    invalid_d = 1'b0;
    nextSym   = slotOf(slots_q, idx_q + 3'd1);

    case (state_q)
      IDLE: begin
        key_d = 1'b0;
        if (bus.start) begin
          if (lookupSpace) begin
            slots_d = '0;
            state_d = WGAP;
            cnt_d   = WGAP_LOAD;
          end else if (lookupSupported) begin
            slots_d = lookupCode;
            idx_d   = 3'd0;
            state_d = MARK;
            key_d   = 1'b1;
            cnt_d   = markLoad(slotOf(lookupCode, 3'd0));
          end else begin
            invalid_d = 1'b1;
          end
        end
      end
      MARK: begin
        if (cnt_q == '0) begin
          key_d = 1'b0;
          if (idx_q < 3'd4 && nextSym != SYM_NONE) begin
            state_d = SPACE;
            cnt_d   = SGAP_LOAD;
          end else begin
            state_d = LGAP;
            cnt_d   = LGAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SPACE: begin
        if (cnt_q == '0) begin
          idx_d   = idx_q + 3'd1;
          state_d = MARK;
          key_d   = 1'b1;
          cnt_d   = markLoad(nextSym);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LGAP, WGAP: begin
        key_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        key_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.key_out     = key_q;
  assign bus.done        = done_q;
  assign bus.letter_done = done_q;
  assign bus.invalid     = invalid_q;
  assign bus.morse_one   = slots_q[9:8];
  assign bus.morse_two   = slots_q[7:6];
  assign bus.morse_three = slots_q[5:4];
  assign bus.morse_four  = slots_q[3:2];
  assign bus.morse_five  = slots_q[1:0];

endmodule

// File: tb/tb_morse_encoder_tx.sv
// Directed bench for morse_encoder_tx with UNIT_CYCLES=4: keying waveforms, slot codes,
// handshake corner cases and reset mid-character.
module tb_morse_encoder_tx;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;

  morse_encoder_tx_if bus();

  morse_encoder_tx #(.UNIT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] slotsNow();
    return {bus.morse_one, bus.morse_two, bus.morse_three, bus.morse_four, bus.morse_five};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Caller is at a negedge; the start pulse is accepted at the following posedge.
  task automatic applyStimulus(input logic [7:0] ch);
    bus.ascii_char = ch;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.ascii_char = 8'h3F;
  endtask

  // Samples key_out on each negedge after the accept edge (sample 1 = first cycle).
  task automatic traceChar(output int doneAt, output logic [127:0] trace, output logic [9:0] slotsAtDone,
                           output logic ldAtDone, output logic readyAtDone, output logic invalidSeen,
                           input bit chain, input logic [7:0] nextCh);
    doneAt      = 0;
    trace       = '0;
    slotsAtDone = '0;
    ldAtDone    = 1'b0;
    readyAtDone = 1'b0;
    invalidSeen = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i < 128) trace[i] = bus.key_out;
      if (bus.invalid) invalidSeen = 1'b1;
      if (bus.done) begin
        doneAt      = i;
        slotsAtDone = slotsNow();
        ldAtDone    = bus.letter_done;
        readyAtDone = bus.ready;
        if (chain) applyStimulus(nextCh);
        break;
      end
    end
  endtask

  // Expected keying from a dot/dash pattern string; empty pattern is a word space.
  task automatic expTrace(input string pat, output logic [127:0] t, output int doneAt);
    int pos;
    int len;
    t   = '0;
    pos = 1;
    for (int j = 0; j < pat.len(); j++) begin
      len = (pat[j] == 8'h2D) ? 12 : 4;
      for (int k = 0; k < len; k++) t[pos + k] = 1'b1;
      pos += len;
      if (j < pat.len() - 1) pos += 4;
    end
    pos += (pat.len() == 0) ? 16 : 12;
    doneAt = pos;
  endtask

  task automatic runAndCheck(input string name, input string pat, input logic [9:0] expSlots,
                             input bit chain, input logic [7:0] nextCh);
    int          doneAt;
    int          expDone;
    logic [127:0] trace;
    logic [127:0] expT;
    logic [9:0]  slotsAtDone;
    logic        ld;
    logic        rdy;
    logic        inv;
    traceChar(doneAt, trace, slotsAtDone, ld, rdy, inv, chain, nextCh);
    expTrace(pat, expT, expDone);
    checkOutput({name, "_doneAt"}, doneAt, expDone);
    checkOutput({name, "_keyTrace"}, trace, expT);
    checkOutput({name, "_slots"}, slotsAtDone, expSlots);
    checkOutput({name, "_letterDone"}, ld, 1'b1);
    checkOutput({name, "_readyAtDone"}, rdy, 1'b1);
    checkOutput({name, "_noInvalid"}, inv, 1'b0);
  endtask

  initial begin
    checkCount     = 0;
    passCount      = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.ascii_char = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);

    checkOutput("rst_ready", bus.ready, 1'b1);
    checkOutput("rst_key", bus.key_out, 1'b0);
    checkOutput("rst_slots", slotsNow(), 10'h000);
    checkOutput("rst_pulses", {bus.done, bus.letter_done, bus.invalid}, 3'b000);
    reset = 1'b0;

    @(negedge clk);
    applyStimulus(8'h45);
    runAndCheck("E", ".", 10'b01_00_00_00_00, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("E_doneOneCycle", bus.done, 1'b0);

    @(negedge clk);
    applyStimulus(8'h41);
    runAndCheck("A", ".-", 10'b01_10_00_00_00, 1'b0, 8'h00);

    @(negedge clk);
    applyStimulus(8'h61);
    runAndCheck("a", ".-", 10'b01_10_00_00_00, 1'b0, 8'h00);

    @(negedge clk);
    applyStimulus(8'h30);
    runAndCheck("zero", "-----", 10'b10_10_10_10_10, 1'b0, 8'h00);

    @(negedge clk);
    applyStimulus(8'h23);
    @(negedge clk);
    checkOutput("hash_invalid", bus.invalid, 1'b1);
    checkOutput("hash_ready", bus.ready, 1'b1);
    checkOutput("hash_key", bus.key_out, 1'b0);
    checkOutput("hash_slotsKept", slotsNow(), 10'b10_10_10_10_10);
    checkOutput("hash_noDone", bus.done, 1'b0);
    applyStimulus(8'h54);
    runAndCheck("T", "-", 10'b10_00_00_00_00, 1'b0, 8'h00);

    // Reset during the second mark of 'O' (marks at cycles 1-12 and 17-28).
    @(negedge clk);
    applyStimulus(8'h4F);
    repeat (20) @(negedge clk);
    checkOutput("O_secondMark", bus.key_out, 1'b1);
    reset          = 1'b1;
    bus.ascii_char = 8'h45;
    bus.start      = 1'b1;
    @(negedge clk);
    checkOutput("O_rst_key", bus.key_out, 1'b0);
    checkOutput("O_rst_ready", bus.ready, 1'b1);
    checkOutput("O_rst_slots", slotsNow(), 10'h000);
    checkOutput("O_rst_noDone", {bus.done, bus.letter_done}, 2'b00);
    @(negedge clk);
    checkOutput("O_rstHold_notAccepted", {bus.ready, bus.key_out}, 2'b10);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.ascii_char = 8'h3F;
    runAndCheck("E_afterReset", ".", 10'b01_00_00_00_00, 1'b0, 8'h00);

    // Back-to-back K, 7, space with start held in each done cycle.
    @(negedge clk);
    applyStimulus(8'h4B);
    runAndCheck("K", "-.-", 10'b10_01_10_00_00, 1'b1, 8'h37);
    runAndCheck("seven", "--...", 10'b10_10_01_01_01, 1'b1, 8'h20);
    runAndCheck("space", "", 10'h000, 1'b0, 8'h00);

    // start while busy is ignored.
    @(negedge clk);
    applyStimulus(8'h45);
    @(negedge clk);
    bus.ascii_char = 8'h54;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("busy_startIgnored_slots", slotsNow(), 10'b01_00_00_00_00);
    repeat (20) @(negedge clk);
    checkOutput("busy_notQueued", {bus.ready, bus.key_out}, 2'b10);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
